// File: rtl/mem_access_ctrl.sv
// Syncram initiator: byte/half/word loads and stores, with sub-word stores done as read-modify-write.
// Define MEM_CTRL_BIG_ENDIAN_EN for the MIPS big-endian lane map; little-endian otherwise.
module mem_access_ctrl #(
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RSP} state_t;

    state_t      r_state, w_next;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;
    logic [31:0] r_addr;
    logic [31:0] r_din;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_misalign;
    logic        w_word_st;
    logic [1:0]  w_blane;
    logic        w_hlane;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_merged;
    logic [31:0] w_load;

    // Strobes decode from state only, so an async reset drops them immediately.
    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RSP);
    assign mem_cs    = (r_state == S_RD) || (r_state == S_WR);
    assign mem_oe    = (r_state == S_RD);
    assign mem_we    = (r_state == S_WR);
    assign mem_addr  = r_addr;
    assign mem_din   = r_din;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    assign w_misalign = MISALIGN_TRAP &&
                        (((req_size == 2'b01) && req_addr[0]) ||
                         (req_size[1] && (req_addr[1:0] != 2'b00)));
    assign w_word_st  = req_we && req_size[1];

`ifdef MEM_CTRL_BIG_ENDIAN_EN
    assign w_blane = ~r_off;
    assign w_hlane = ~r_off[1];
`else
    assign w_blane = r_off;
    assign w_hlane = r_off[1];
`endif

    assign w_byte = mem_dout[{w_blane, 3'b000} +: 8];
    assign w_half = mem_dout[{w_hlane, 4'b0000} +: 16];

    always_comb begin
        w_merged = mem_dout;
        case (r_size)
            2'b00:   w_merged[{w_blane, 3'b000} +: 8]  = r_wdata[7:0];
            2'b01:   w_merged[{w_hlane, 4'b0000} +: 16] = r_wdata;
            default: w_merged = mem_dout;
        endcase
    end

    always_comb begin
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = mem_dout;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_misalign)     w_next = S_RSP;
                    else if (w_word_st) w_next = S_WR;
                    else                w_next = S_RD;
                end
            end
            S_RD:    w_next = S_CAP;
            S_CAP:   w_next = r_we ? S_WR : S_RSP;
            S_WR:    w_next = S_RSP;
            S_RSP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_off    <= 2'b00;
            r_wdata  <= 16'h0;
            r_addr   <= 32'h0;
            r_din    <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_we     <= req_we;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_off    <= req_addr[1:0];
                r_wdata  <= req_wdata[15:0];
                r_addr   <= {req_addr[31:2], 2'b00};
                r_err    <= w_misalign;
                if (w_word_st)
                    r_din <= req_wdata;
            end
            // Read data is consumed straight off the bus at the capture edge.
            if (r_state == S_CAP) begin
                if (r_we) r_din   <= w_merged;
                else      r_rdata <= w_load;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural syncram model on the memory port.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_cs, mem_oe, mem_we;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout = 32'h0;

    logic [31:0] mem [0:63];

    int errs = 0;
    int checks = 0;
    int n_we, n_oe, n_cs, n_both;
    logic [31:0] last_waddr, last_wdin;

    mem_access_ctrl #(.MISALIGN_TRAP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_cs && mem_we) mem[mem_addr[7:2]] <= mem_din;
        if (mem_cs && mem_oe) mem_dout <= mem[mem_addr[7:2]];
    end

    always @(negedge clk) begin
        if (mem_cs && mem_we) begin
            n_we++;
            last_waddr = mem_addr;
            last_wdin  = mem_din;
        end
        if (mem_cs && mem_oe) n_oe++;
        if (mem_cs) n_cs++;
        if (mem_oe && mem_we) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Issues one request and returns the accept-to-rsp_valid latency (0 = timed out).
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        n_we = 0; n_oe = 0; n_cs = 0; n_both = 0;
        last_waddr = 32'hx; last_wdin = 32'hx;
        req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            if (rsp_valid) begin lat = n; break; end
        end
        @(posedge clk); #1;
    endtask

    int lat;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        #2;
        req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b1; req_size = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", {31'b0, mem_cs}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", {31'b0, rsp_err}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_din", mem_din, 32'h0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", {31'b0, req_ready}, 32'h1);

        // sw 0x10
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat);
        chk("sw_lat", lat, 2);
        chk("sw_we_cycles", n_we, 1);
        chk("sw_oe_cycles", n_oe, 0);
        chk("sw_addr", last_waddr, 32'h10);
        chk("sw_din", last_wdin, 32'hDEADBEEF);
        chk("sw_mem", mem[4], 32'hDEADBEEF);

        // lw 0x10
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat);
        chk("lw_lat", lat, 3);
        chk("lw_oe_cycles", n_oe, 1);
        chk("lw_we_cycles", n_we, 0);
        chk("lw_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("lw_err", {31'b0, rsp_err}, 32'h0);

        // sb 0x13
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AA, lat);
        chk("sb_lat", lat, 4);
        chk("sb_oe_cycles", n_oe, 1);
        chk("sb_we_cycles", n_we, 1);
`ifdef MEM_CTRL_BIG_ENDIAN_EN
        chk("sb_din", last_wdin, 32'hDEADBEAA);
`else
        chk("sb_din", last_wdin, 32'hAAADBEEF);
`endif
        chk("sb_mem", mem[4], last_wdin);

        // Loads over a fixed word so both lane maps have known answers.
        mem[4] = 32'hAAADBEEF;
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat);
        chk("lh_lat", lat, 3);
`ifdef MEM_CTRL_BIG_ENDIAN_EN
        chk("lh_s", rsp_rdata, 32'hFFFFBEEF);
`else
        chk("lh_s", rsp_rdata, 32'hFFFFAAAD);
`endif
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat);
`ifdef MEM_CTRL_BIG_ENDIAN_EN
        chk("lhu", rsp_rdata, 32'h0000BEEF);
`else
        chk("lhu", rsp_rdata, 32'h0000AAAD);
`endif
        do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, lat);
`ifdef MEM_CTRL_BIG_ENDIAN_EN
        chk("lb_s", rsp_rdata, 32'hFFFFFFAA);
`else
        chk("lb_s", rsp_rdata, 32'hFFFFFFEF);
`endif
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat);
`ifdef MEM_CTRL_BIG_ENDIAN_EN
        chk("lbu", rsp_rdata, 32'h000000AD);
`else
        chk("lbu", rsp_rdata, 32'h000000BE);
`endif

        // sh 0x10
        do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF1234, lat);
        chk("sh_lat", lat, 4);
`ifdef MEM_CTRL_BIG_ENDIAN_EN
        chk("sh_mem", mem[4], 32'h1234BEEF);
`else
        chk("sh_mem", mem[4], 32'hAAAD1234);
`endif
        chk("oe_we_overlap", n_both, 0);

        // Misaligned lw and sh
        do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, lat);
        chk("mis_lw_lat", lat, 1);
        chk("mis_lw_err", {31'b0, rsp_err}, 32'h1);
        chk("mis_lw_cs", n_cs, 0);
        mem[5] = 32'h55667788;
        do_req(1'b1, 2'b01, 1'b0, 32'h15, 32'h0000ABCD, lat);
        chk("mis_sh_lat", lat, 1);
        chk("mis_sh_cs", n_cs, 0);
        chk("mis_sh_mem", mem[5], 32'h55667788);
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat);
        chk("aligned_err_clr", {31'b0, rsp_err}, 32'h0);
        chk("lw14", rsp_rdata, 32'h55667788);

        // Reset during WR
        mem[8] = 32'h11111111;
        n_cs = 0;
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wr_we_before_rst", {31'b0, mem_we}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_we_drop", {31'b0, mem_we}, 32'h0);
        chk("rst_cs_drop", {31'b0, mem_cs}, 32'h0);
        begin
            int seen;
            seen = 0;
            repeat (3) begin
                @(posedge clk); #1;
                if (rsp_valid) seen++;
            end
            rst_n = 1'b1;
            repeat (2) begin
                @(posedge clk); #1;
                if (rsp_valid) seen++;
            end
            chk("rst_no_rsp", seen, 0);
        end
        chk("rst_mem_kept", mem[8], 32'h11111111);
        chk("rst_ready_after", {31'b0, req_ready}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
